sccb_arbiter: RTL

Shares the single SCCB command port of the camera's serial sender among several requesters. Typical requesters are the power-up register sequencer and runtime tuners such as exposure or white-balance loops. The block sits between the requesters and `i2c_sender`. It latches one (register, value) pair per grant, drives `send` until the sender signals `taken`, acknowledges the winner, then enforces a bus-settle gap before the next grant. Arbitration is round-robin, with an optional per-requester lock for atomic bursts.

---
 rtl/sccb_pkg.sv | 13 +
 rtl/sccb_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sccb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command-port arbiter.
package sccb_pkg;

   localparam int unsigned SCCB_DATA_W = 8;
   localparam logic [SCCB_DATA_W-1:0] SCCB_ID_OV7670 = 8'h42;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } sccb_arb_state_t;

endpackage : sccb_pkg

// File: rtl/sccb_arbiter_if.sv
// Requester and sender side signals of the SCCB arbiter.
interface sccb_arbiter_if
   import sccb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_lock;
   logic [NUM_REQ*SCCB_DATA_W-1:0] req_regis;
   logic [NUM_REQ*SCCB_DATA_W-1:0] req_value;
   logic [NUM_REQ-1:0]             req_ack;
   logic [NUM_REQ-1:0]             req_err;
   logic                           snd_send;
   logic                           snd_taken;
   logic [SCCB_DATA_W-1:0]         snd_id;
   logic [SCCB_DATA_W-1:0]         snd_regis;
   logic [SCCB_DATA_W-1:0]         snd_value;
   logic                           busy;
   logic [IDX_W-1:0]               grant_idx;

   // Arbiter view
   modport master (
      input  req_valid, req_lock, req_regis, req_value, snd_taken,
      output req_ack, req_err, snd_send, snd_id, snd_regis, snd_value, busy, grant_idx
   );

   // Requester / sender view
   modport slave (
      output req_valid, req_lock, req_regis, req_value, snd_taken,
      input  req_ack, req_err, snd_send, snd_id, snd_regis, snd_value, busy, grant_idx
   );

endinterface : sccb_arbiter_if

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search starting at ptr.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_c,
   output logic [IDX_W-1:0]   idx_c
);

   // First valid requester at or after ptr, wrapping around
   always_comb begin
      logic [IDX_W-1:0] j;
      logic             found;
      j     = '0;
      found = 1'b0;
      gnt_c = '0;
      idx_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = IDX_W'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[j]) begin
            found    = 1'b1;
            gnt_c[j] = 1'b1;
            idx_c    = j;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB sender among NUM_REQ requesters.
// Optional watchdog on the ISSUE state: define SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter
   import sccb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter logic [SCCB_DATA_W-1:0] DEV_ID = SCCB_ID_OV7670,
   parameter int unsigned SETTLE_CYCLES = 16
`ifdef SCCB_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic          clk,
   input  logic          rst,
   sccb_arbiter_if.master bus
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned DW     = SCCB_DATA_W;
   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam bit          NO_GAP = (SETTLE_CYCLES == 0);

   sccb_arb_state_t  state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [DW-1:0]    regis_q, regis_d;
   logic [DW-1:0]    value_q, value_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic             send_q, send_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_REQ-1:0] win_gnt;
   logic [IDX_W-1:0] win_idx;
   logic             lock_ok_c;

`ifdef SCCB_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            abort_q, abort_d;
   assign lock_ok_c = !abort_q;
`else
   assign lock_ok_c = 1'b1;
`endif

   function automatic logic [DW-1:0] pick(input logic [NUM_REQ*DW-1:0] v,
                                          input logic [IDX_W-1:0] i);
      return v[DW*32'(i) +: DW];
   endfunction

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (ptr_q),
      .gnt_c (win_gnt),
      .idx_c (win_idx)
   );

   // Next-state, payload latch and pulse generation
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      regis_d = regis_q;
      value_d = value_q;
      ack_d   = '0;
      err_d   = '0;
      cnt_d   = cnt_q;
`ifdef SCCB_ARB_TIMEOUT_EN
      wd_d    = '0;
      abort_d = abort_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|win_gnt) begin
               state_d = ISSUE;
               grant_d = win_idx;
               regis_d = pick(bus.req_regis, win_idx);
               value_d = pick(bus.req_value, win_idx);
               ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end
         end
         ISSUE: begin
`ifdef SCCB_ARB_TIMEOUT_EN
            wd_d = wd_q + WD_W'(1);
`endif
            if (bus.snd_taken) begin
               ack_d[grant_q] = 1'b1;
               cnt_d          = '0;
               state_d        = NO_GAP ? IDLE : GAP;
`ifdef SCCB_ARB_TIMEOUT_EN
               abort_d        = 1'b0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               err_d[grant_q] = 1'b1;
               cnt_d          = '0;
               abort_d        = 1'b1;
               state_d        = NO_GAP ? IDLE : GAP;
`endif
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               // Locked requester with a new command keeps the bus; ptr untouched
               if (lock_ok_c && bus.req_lock[grant_q] && bus.req_valid[grant_q]) begin
                  state_d = ISSUE;
                  regis_d = pick(bus.req_regis, grant_q);
                  value_d = pick(bus.req_value, grant_q);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      send_d = (state_d == ISSUE);
      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         regis_q <= '0;
         value_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         send_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         regis_q <= regis_d;
         value_q <= value_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         send_q  <= send_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SCCB_ARB_TIMEOUT_EN
   // ISSUE watchdog registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q    <= '0;
         abort_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         abort_q <= abort_d;
      end
   end
`endif

   assign bus.req_ack   = ack_q;
   assign bus.req_err   = err_q;
   assign bus.snd_send  = send_q;
   assign bus.snd_id    = DEV_ID;
   assign bus.snd_regis = regis_q;
   assign bus.snd_value = value_q;
   assign bus.busy      = busy_q;
   assign bus.grant_idx = grant_q;

endmodule : sccb_arbiter
